// File: rtl/uart_tx_param.sv
//==============================================================================
// Module   : uart_tx_param
// Purpose  : Parametrised UART transmitter: start bit, LSB-first data,
//            optional parity, one or two stop bits, valid/ready input.
// Option   : `define UART_TX_HOLD_EN adds a one-entry holding register.
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module uart_tx_param #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  stop2,
  output logic                  ready,
  output logic                  TX_out,
  output logic                  busy
);

  localparam int c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int c_idx_w = $clog2(DATA_WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
  logic [c_idx_w-1:0]    r_idx, w_idx_nxt;
  logic                  r_stop_second, w_stop_second_nxt;
  logic                  r_tx, w_tx_nxt;
  logic                  w_shift_en;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_stop2;

  logic                  w_accept;
  logic                  w_bit_end;
  logic                  w_frame_end;
  logic                  w_start_in;
  logic                  w_start_hold;
  logic                  w_start;
  logic [DATA_WIDTH-1:0] w_ld_data;
  logic                  w_ld_par_en;
  logic                  w_ld_par_typ;
  logic                  w_ld_stop2;

  assign w_accept    = data_valid && ready;
  assign w_bit_end   = (r_cnt == c_cnt_last);
  assign w_frame_end = (r_state == S_STOP) && w_bit_end && (!r_stop2 || r_stop_second);
  // A new frame starts from IDLE or straight out of the last stop cycle.
  assign w_start_in  = w_accept && ((r_state == S_IDLE) || w_frame_end);
  assign w_start     = w_start_in || w_start_hold;
  assign busy        = (r_state != S_IDLE);
  assign TX_out      = r_tx;

`ifdef UART_TX_HOLD_EN
  logic                  r_hold_full;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic                  r_hold_par_en;
  logic                  r_hold_par_typ;
  logic                  r_hold_stop2;
  logic                  w_hold_wr;

  assign ready        = !r_hold_full;
  assign w_start_hold = w_frame_end && r_hold_full;
  assign w_hold_wr    = w_accept && busy && !w_frame_end;
  assign w_ld_data    = w_start_hold ? r_hold_data    : p_data;
  assign w_ld_par_en  = w_start_hold ? r_hold_par_en  : par_en;
  assign w_ld_par_typ = w_start_hold ? r_hold_par_typ : par_typ;
  assign w_ld_stop2   = w_start_hold ? r_hold_stop2   : stop2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hold_full    <= 1'b0;
      r_hold_data    <= '0;
      r_hold_par_en  <= 1'b0;
      r_hold_par_typ <= 1'b0;
      r_hold_stop2   <= 1'b0;
    end else if (w_start_hold) begin
      r_hold_full <= 1'b0;
    end else if (w_hold_wr) begin
      r_hold_full    <= 1'b1;
      r_hold_data    <= p_data;
      r_hold_par_en  <= par_en;
      r_hold_par_typ <= par_typ;
      r_hold_stop2   <= stop2;
    end
  end
`else
  assign ready        = !busy;
  assign w_start_hold = 1'b0;
  assign w_ld_data    = p_data;
  assign w_ld_par_en  = par_en;
  assign w_ld_par_typ = par_typ;
  assign w_ld_stop2   = stop2;
`endif

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = w_bit_end ? '0 : r_cnt + c_cnt_w'(1);
    w_idx_nxt         = r_idx;
    w_stop_second_nxt = r_stop_second;
    w_tx_nxt          = r_tx;
    w_shift_en        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt         = '0;
        w_tx_nxt          = 1'b1;
        w_stop_second_nxt = 1'b0;
        if (w_start) begin
          w_state_nxt = S_START;
          w_tx_nxt    = 1'b0;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          if (r_idx == c_idx_last) begin
            w_stop_second_nxt = 1'b0;
            if (r_par_en) begin
              w_state_nxt = S_PARITY;
              w_tx_nxt    = r_par_bit;
            end else begin
              w_state_nxt = S_STOP;
              w_tx_nxt    = 1'b1;
            end
          end else begin
            // r_shift[0] holds the bit on the line, so [1] is the next one.
            w_idx_nxt  = r_idx + c_idx_w'(1);
            w_tx_nxt   = r_shift[1];
            w_shift_en = 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt       = S_STOP;
          w_tx_nxt          = 1'b1;
          w_stop_second_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          if (r_stop2 && !r_stop_second) begin
            w_stop_second_nxt = 1'b1;
          end else if (w_start) begin
            w_state_nxt       = S_START;
            w_tx_nxt          = 1'b0;
            w_stop_second_nxt = 1'b0;
          end else begin
            w_state_nxt       = S_IDLE;
            w_tx_nxt          = 1'b1;
            w_stop_second_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_stop_second <= 1'b0;
      r_tx          <= 1'b1;
      r_shift       <= '0;
      r_par_en      <= 1'b0;
      r_par_bit     <= 1'b0;
      r_stop2       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_idx         <= w_idx_nxt;
      r_stop_second <= w_stop_second_nxt;
      r_tx          <= w_tx_nxt;
      if (w_start) begin
        r_shift   <= w_ld_data;
        r_par_en  <= w_ld_par_en;
        r_par_bit <= (^w_ld_data) ^ w_ld_par_typ;
        r_stop2   <= w_ld_stop2;
      end else if (w_shift_en) begin
        r_shift <= r_shift >> 1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_param.sv
//==============================================================================
// Module   : tb_uart_tx_param
// Purpose  : Self-checking bench for uart_tx_param (1 and 4 clocks per bit).
// Revision : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic       stop2;
  logic [7:0] p_data;
  logic       ready1, tx1, busy1;
  logic       ready4, tx4, busy4;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  bit wave[$];

  always #5 clk = ~clk;

  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
    .ready(ready1), .TX_out(tx1), .busy(busy1)
  );

  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .stop2(stop2),
    .ready(ready4), .TX_out(tx4), .busy(busy4)
  );

  function automatic void check1(string name, logic act, logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void checkn(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a frame is a list of bit slots of CLKS_PER_BIT cycles each.
  typedef struct {
    bit active; int pos; logic [7:0] d; bit pe; bit pt; bit s2;
    bit pend; logic [7:0] pd; bit ppe; bit ppt; bit ps2;
  } mstate_t;
  mstate_t m[2];

  function automatic int cpb(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int flen(int i, bit pe, bit s2);
    return (10 + int'(pe) + int'(s2)) * cpb(i);
  endfunction

  function automatic logic m_tx(int i);
    int b;
    if (!m[i].active) return 1'b1;
    b = m[i].pos / cpb(i);
    if (b == 0) return 1'b0;
    if (b <= 8) return m[i].d[b-1];
    if (b == 9 && m[i].pe) return (^m[i].d) ^ m[i].pt;
    return 1'b1;
  endfunction

  function automatic logic m_ready(int i);
`ifdef UART_TX_HOLD_EN
    return !m[i].pend;
`else
    return !m[i].active;
`endif
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      mstate_t s;
      bit      acc;
      s   = m[i];
      acc = data_valid && m_ready(i);
      if (!rst) begin
        s.active = 1'b0; s.pend = 1'b0; s.pos = 0;
      end else begin
        if (s.active) begin
          if (s.pos == flen(i, s.pe, s.s2) - 1) begin
            s.active = 1'b0; s.pos = 0;
          end else begin
            s.pos++;
          end
        end
        if (acc) begin
          if (!s.active) begin
            s.active = 1'b1; s.pos = 0;
            s.d = p_data; s.pe = par_en; s.pt = par_typ; s.s2 = stop2;
          end else begin
            s.pend = 1'b1;
            s.pd = p_data; s.ppe = par_en; s.ppt = par_typ; s.ps2 = stop2;
          end
        end
        if (!s.active && s.pend) begin
          s.active = 1'b1; s.pos = 0;
          s.d = s.pd; s.pe = s.ppe; s.pt = s.ppt; s.s2 = s.ps2;
          s.pend = 1'b0;
        end
      end
      m[i] <= s;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check1("sb1.tx", tx1, m_tx(0));
      check1("sb1.busy", busy1, m[0].active);
      check1("sb1.ready", ready1, m_ready(0));
      check1("sb4.tx", tx4, m_tx(1));
      check1("sb4.busy", busy4, m[1].active);
      check1("sb4.ready", ready4, m_ready(1));
    end
  end

  function automatic logic cur_tx(int sel);
    return (sel == 0) ? tx1 : tx4;
  endfunction
  function automatic logic cur_busy(int sel);
    return (sel == 0) ? busy1 : busy4;
  endfunction
  function automatic logic cur_ready(int sel);
    return (sel == 0) ? ready1 : ready4;
  endfunction

  function automatic logic [7:0] wave_byte(int off, int stride);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = wave[off + j * stride];
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((busy1 || busy4 || !ready1 || !ready4) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkn("idle.timeout", n, 0);
  endtask

  // Send one word, then record the selected line until busy drops.
  // Inputs are inverted after acceptance; inject_at >= 0 offers 0xFF mid-frame.
  task automatic send_and_capture(input int sel, input logic [7:0] d, input bit pe,
                                  input bit pt, input bit s2, input int inject_at);
    int n = 0;
    wait_idle();
    p_data = d; par_en = pe; par_typ = pt; stop2 = s2; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    p_data = ~d; par_en = ~pe; par_typ = ~pt; stop2 = ~s2;
    wave.delete();
    while (cur_busy(sel) && n < 400) begin
      wave.push_back(cur_tx(sel));
      if (n == inject_at) begin
        check1("drop.ready", cur_ready(sel), 1'b0);
        p_data = 8'hFF; data_valid = 1'b1;
      end
      @(negedge clk);
      data_valid = 1'b0;
      n++;
    end
    if (n >= 400) checkn("capture.timeout", n, 0);
  endtask

  typedef struct {
    logic [7:0] d; bit pe; bit pt; bit s2; int len; bit par;
  } vec_t;
  vec_t vt[7];

  initial begin
    bit exp2[11];
    bit exp3[11];
    int n6;
    rst = 1'b0; data_valid = 1'b0; p_data = 8'h00;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0;
    vt[0] = '{d: 8'h32, pe: 1'b1, pt: 1'b0, s2: 1'b0, len: 11, par: 1'b1};
    vt[1] = '{d: 8'h32, pe: 1'b1, pt: 1'b1, s2: 1'b0, len: 11, par: 1'b0};
    vt[2] = '{d: 8'h00, pe: 1'b0, pt: 1'b0, s2: 1'b0, len: 10, par: 1'b0};
    vt[3] = '{d: 8'hFF, pe: 1'b1, pt: 1'b0, s2: 1'b1, len: 12, par: 1'b0};
    vt[4] = '{d: 8'h81, pe: 1'b1, pt: 1'b1, s2: 1'b1, len: 12, par: 1'b1};
    vt[5] = '{d: 8'h7F, pe: 1'b1, pt: 1'b0, s2: 1'b0, len: 11, par: 1'b1};
    vt[6] = '{d: 8'hC4, pe: 1'b0, pt: 1'b1, s2: 1'b1, len: 11, par: 1'b0};
    exp2 = '{0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1};
    exp3 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 1};

    repeat (3) @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Reset held for two cycles while idle
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check1("rst.tx", tx1, 1'b1);
    check1("rst.busy", busy1, 1'b0);
    check1("rst.ready", ready1, 1'b1);
    check1("rst.ready4", ready4, 1'b1);

    // Table of single frames on the one-clock-per-bit instance
    for (int k = 0; k < 7; k++) begin
      send_and_capture(0, vt[k].d, vt[k].pe, vt[k].pt, vt[k].s2, -1);
      checkn("vec.len", wave.size(), vt[k].len);
      if (wave.size() == vt[k].len) begin
        check1("vec.start", wave[0], 1'b0);
        checkn("vec.data", int'(wave_byte(1, 1)), int'(vt[k].d));
        if (vt[k].pe) check1("vec.parity", wave[9], vt[k].par);
        check1("vec.stop", wave[vt[k].len-1], 1'b1);
        if (vt[k].s2) check1("vec.stop2", wave[vt[k].len-2], 1'b1);
      end
    end

    // Exact waveform of 0x32 with even parity
    send_and_capture(0, 8'h32, 1'b1, 1'b0, 1'b0, -1);
    checkn("t2.len", wave.size(), 11);
    if (wave.size() == 11)
      for (int k = 0; k < 11; k++) check1("t2.bit", wave[k], exp2[k]);

    // Four clocks per bit, no parity, two stop bits
    send_and_capture(1, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
    checkn("t3.len", wave.size(), 44);
    if (wave.size() == 44)
      for (int k = 0; k < 44; k++) check1("t3.bit", wave[k], exp3[k/4]);

`ifndef UART_TX_HOLD_EN
    // Word offered during data bit 2 must be dropped
    send_and_capture(0, 8'h32, 1'b1, 1'b0, 1'b0, 3);
    checkn("t4.len", wave.size(), 11);
    if (wave.size() == 11)
      for (int k = 0; k < 11; k++) check1("t4.bit", wave[k], exp2[k]);
    repeat (3) begin
      check1("t4.idle_tx", tx1, 1'b1);
      check1("t4.idle_busy", busy1, 1'b0);
      @(negedge clk);
    end
`endif

    // Abort during data bit 3, then a clean 0x0F frame
    wait_idle();
    p_data = 8'h32; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check1("t5.tx", tx1, 1'b1);
    check1("t5.busy", busy1, 1'b0);
    check1("t5.busy4", busy4, 1'b0);
    send_and_capture(0, 8'h0F, 1'b0, 1'b0, 1'b0, -1);
    checkn("t5.len", wave.size(), 10);
    if (wave.size() == 10) begin
      check1("t5.start", wave[0], 1'b0);
      checkn("t5.data", int'(wave_byte(1, 1)), 'h0F);
      check1("t5.stop", wave[9], 1'b1);
    end

`ifdef UART_TX_HOLD_EN
    // Back-to-back frames through the holding register
    wait_idle();
    p_data = 8'h55; par_en = 1'b1; par_typ = 1'b0; stop2 = 1'b0; data_valid = 1'b1;
    @(negedge clk);
    wave.delete();
    check1("t6.ready_empty", ready1, 1'b1);
    wave.push_back(tx1);
    p_data = 8'hAA;
    @(negedge clk);
    data_valid = 1'b0;
    check1("t6.ready_full", ready1, 1'b0);
    n6 = 0;
    while (busy1 && n6 < 100) begin
      wave.push_back(tx1);
      if (wave.size() == 12) check1("t6.ready_free", ready1, 1'b1);
      @(negedge clk);
      n6++;
    end
    checkn("t6.len", wave.size(), 22);
    if (wave.size() == 22) begin
      check1("t6.stop1", wave[10], 1'b1);
      check1("t6.start2", wave[11], 1'b0);
      checkn("t6.data1", int'(wave_byte(1, 1)), 'h55);
      checkn("t6.data2", int'(wave_byte(12, 1)), 'hAA);
      check1("t6.par2", wave[20], 1'b0);
    end
`endif

    // Random traffic against the reference model, with occasional resets
    wait_idle();
    for (int c = 0; c < 2000; c++) begin
      data_valid = ($urandom_range(0, 3) == 0);
      p_data     = 8'($urandom);
      par_en     = 1'($urandom_range(0, 1));
      par_typ    = 1'($urandom_range(0, 1));
      stop2      = 1'($urandom_range(0, 1));
      rst        = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rst = 1'b1;
    data_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
- Parametrised UART transmitter; successor to the fixed 8-bit, one-bit-per-clock UART TX.
- Serialises a DATA_WIDTH word as: start bit, data LSB-first, optional parity, 1 or 2 stop bits.
- Adds a baud divider, a selectable stop-bit count and a valid/ready handshake.
- Sits between the register/bus interface and the serial TX pad.

Parameters:
DATA_WIDTH, 8, data bits per frame; legal range 5..9.
CLKS_PER_BIT, 1, clk cycles per serial bit; must be >= 1. Counter width is derived internally with $clog2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-low reset.
p_data  input  DATA_WIDTH  parallel word to transmit.
data_valid  input  1  p_data is valid; accepted when data_valid && ready.
par_en  input  1  1 = insert parity bit.
par_typ  input  1  0 = even parity, 1 = odd parity.
stop2  input  1  0 = one stop bit, 1 = two stop bits.
ready  output  1  block can accept a word this cycle.
TX_out  output  1  serial line, registered; idles high.
busy  output  1  a frame is in progress.

Behaviour:
- Reset (rst=0 at a clk edge): state=IDLE, TX_out=1, busy=0, hold register empty. ready=1 from the first cycle after reset; data_valid is ignored while rst=0.
- Acceptance: on the edge where data_valid && ready, latch p_data, par_en, par_typ and stop2. Input changes after acceptance have no effect on the frame.
- Latency: the start bit (TX_out=0) and busy=1 appear on the edge that accepts the word.
- FSM states: IDLE -> START -> DATA -> (PARITY if par_en) -> STOP -> IDLE.
- Bit timing: every bit holds for exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads at each bit boundary.
- DATA state: a bit index counts 0..DATA_WIDTH-1 and transmits LSB first.
- Parity bit: even = XOR of the latched data; odd = inverted XOR.
- STOP state: TX_out=1 for CLKS_PER_BIT cycles, or 2*CLKS_PER_BIT cycles when stop2=1.
- Frame length in cycles: (1 + DATA_WIDTH + par_en + 1 + stop2) * CLKS_PER_BIT.
- busy: high from the acceptance edge through the final stop cycle; low on the following edge unless another frame starts back-to-back.
- ready (base build): ready = !busy.
- data_valid while ready=0: ignored; the word is not queued and the current frame is not disturbed.
- Reset mid-frame: the frame is aborted. The next cycle shows TX_out=1, busy=0, and the counters are cleared. There is no partial-frame completion.
- CLKS_PER_BIT=1: the baud counter is degenerate and one bit is sent per clk.

Optional Feature:
UART_TX_HOLD_EN
- Defined: adds a one-entry holding register (data plus latched config). ready = !hold_full.
  - While busy, a handshake writes the hold register.
  - At the last cycle of STOP with hold_full=1, the FSM goes directly to START on the next edge with no idle cycle. busy stays high and hold_full clears; config comes from the hold entry.
  - In IDLE with the hold register empty, a handshake starts the frame directly, as in the base build.
  - Reset clears hold_full.
- Undefined: no holding register; ready = !busy.

Test Plan:
1. Reset: hold rst=0 for 2 cycles mid-idle -> TX_out=1, busy=0, ready=1 after release.
2. DATA_WIDTH=8, CLKS_PER_BIT=1, par_en=1, par_typ=0, stop2=0, p_data=0x32 -> TX_out = 0, 0,1,0,0,1,1,0,0, 1 (even parity), 1 (stop); busy high for exactly 11 cycles; repeating with par_typ=1 gives parity bit 0.
3. CLKS_PER_BIT=4, par_en=0, stop2=1, p_data=0xA5 -> each bit lasts 4 cycles, data pattern 1,0,1,0,0,1,0,1, busy high for 44 cycles, TX_out high for the last 8.
4. Base build: data_valid=1 with p_data=0xFF asserted at data bit 2 of a 0x32 frame -> ready=0, word dropped, line carries only the 0x32 frame, then idles.
5. rst=0 for one cycle during data bit 3 -> next cycle TX_out=1, busy=0. A following 0x0F frame is transmitted correctly.
6. UART_TX_HOLD_EN, CLKS_PER_BIT=1: send 0x55, then 0xAA while busy -> second start bit immediately follows the first stop bit, busy stays high for 22 cycles, ready low only while the hold register is full.
